// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: word-wide data port, byte lanes, extended load data, pipeline stall.
// Latency: store >=2 cycles, load >=3 cycles from acceptance to wb_valid; timeout after MAX_WAIT wait cycles.
// Backpressure: holds mem_req until mem_ready and holds stall until DONE; optional MEM_MISALIGN_TRAP_EN adds misalign trap.
module mem_access_unit #(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [4:0]        ex_opcode,
  input  logic [31:0]       ex_addr,
  input  logic [31:0]       ex_wdata,
  output logic              stall,
  output logic              wb_valid,
  output logic [31:0]       wb_data,
  output logic              err_timeout,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
`ifdef MEM_MISALIGN_TRAP_EN
  , output logic            misalign
`endif
);

  localparam logic [4:0] OP_LW = 5'b01101, OP_LH = 5'b01110, OP_LHU = 5'b01111,
                         OP_LB = 5'b10000, OP_LBU = 5'b10001, OP_SW = 5'b10010,
                         OP_SH = 5'b10011, OP_SB = 5'b10100;
  localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;
  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state;

  logic          is_mem, is_store;
  logic [1:0]    sz, lane;
  logic [3:0]    be;
  logic [31:0]   wdata_rep;
  logic [4:0]    op_r;
  logic [1:0]    lane_r;
  logic [CW-1:0] cnt;
  logic [15:0]   half_sel;
  logic [7:0]    byte_sel;
  logic [31:0]   ld_data;

  always_comb begin
    is_mem   = 1'b1;
    is_store = 1'b0;
    sz       = SZ_B;
    case (ex_opcode)
      OP_LW:         sz = SZ_W;
      OP_LH, OP_LHU: sz = SZ_H;
      OP_LB, OP_LBU: sz = SZ_B;
      OP_SW:         begin sz = SZ_W; is_store = 1'b1; end
      OP_SH:         begin sz = SZ_H; is_store = 1'b1; end
      OP_SB:         begin sz = SZ_B; is_store = 1'b1; end
      default:       is_mem = 1'b0;
    endcase
  end

  // Lane is the naturally aligned offset; unaligned low bits are dropped here.
  always_comb begin
    lane      = ex_addr[1:0];
    be        = 4'b0001 << ex_addr[1:0];
    wdata_rep = {4{ex_wdata[7:0]}};
    case (sz)
      SZ_W: begin
        lane      = 2'b00;
        be        = 4'b1111;
        wdata_rep = ex_wdata;
      end
      SZ_H: begin
        lane      = {ex_addr[1], 1'b0};
        be        = ex_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{ex_wdata[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned;
  always_comb begin
    misaligned = 1'b0;
    if (sz == SZ_W)      misaligned = |ex_addr[1:0];
    else if (sz == SZ_H) misaligned = ex_addr[0];
  end
`endif

  always_comb begin
    half_sel = lane_r[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    byte_sel = mem_rdata[{lane_r, 3'b000} +: 8];
    case (op_r)
      OP_LH:   ld_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  ld_data = {16'h0000, half_sel};
      OP_LB:   ld_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  ld_data = {24'h000000, byte_sel};
      default: ld_data = mem_rdata;
    endcase
  end

  assign stall = (state == REQ) || (state == WAIT) || ((state == IDLE) && ex_valid && is_mem);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      op_r        <= '0;
      lane_r      <= '0;
      wb_valid    <= 1'b0;
      wb_data     <= '0;
      err_timeout <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_be      <= '0;
      mem_wdata   <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign    <= 1'b0;
`endif
    end else begin
      wb_valid    <= 1'b0;
      err_timeout <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign    <= 1'b0;
`endif
      case (state)
        IDLE: if (ex_valid && is_mem) begin
          op_r   <= ex_opcode;
          lane_r <= lane;
`ifdef MEM_MISALIGN_TRAP_EN
          if (misaligned) begin
            state    <= DONE;
            wb_valid <= 1'b1;
            wb_data  <= '0;
            misalign <= 1'b1;
          end else
`endif
          begin
            state     <= REQ;
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            mem_addr  <= {ex_addr[ADDR_W-1:2], 2'b00};
            mem_be    <= be;
            mem_wdata <= wdata_rep;
          end
        end
        REQ: if (mem_ready) begin
          mem_req <= 1'b0;
          cnt     <= '0;
          if (mem_we) begin
            state    <= DONE;
            wb_valid <= 1'b1;
            wb_data  <= '0;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // rvalid wins over a timeout expiring in the same cycle
          if (mem_rvalid) begin
            state    <= DONE;
            wb_valid <= 1'b1;
            wb_data  <= ld_data;
          end else if (cnt == CW'(MAX_WAIT - 1)) begin
            state       <= DONE;
            wb_valid    <= 1'b1;
            wb_data     <= '0;
            err_timeout <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit with a spec-level reference model.
module tb_mem_access_unit;
  localparam int MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [4:0]  ex_opcode = '0;
  logic [31:0] ex_addr = '0, ex_wdata = '0;
  logic        stall, wb_valid, err_timeout, mem_req, mem_we;
  logic [31:0] wb_data, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  mem_access_unit #(.ADDR_W(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .stall(stall), .wb_valid(wb_valid),
    .wb_data(wb_data), .err_timeout(err_timeout), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign(misalign)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; logic [3:0] be; logic [31:0] wd; logic we;} req_t;
  typedef struct {logic [31:0] d; logic err; logic mis;} wb_t;
  req_t rq[$];
  wb_t  wq[$];
  int total = 0, bad = 0;

  localparam logic [4:0] OPS [8] = '{5'b01101, 5'b01110, 5'b01111, 5'b10000,
                                     5'b10001, 5'b10010, 5'b10011, 5'b10100};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Request monitor: every cycle mem_req is up, the port must match the oldest expected request.
  always @(negedge clk) if (rst_n && mem_req) begin
    if (rq.size() == 0) chk("req_unexpected", mem_req, 0);
    else begin
      chk("mem_addr", mem_addr, rq[0].addr);
      chk("mem_be", mem_be, rq[0].be);
      chk("mem_we", mem_we, rq[0].we);
      if (rq[0].we) chk("mem_wdata", mem_wdata, rq[0].wd);
      chk("stall_req", stall, 1);
      if (mem_ready) void'(rq.pop_front());
    end
  end

  // Writeback monitor.
  always @(negedge clk) if (rst_n) begin
    if (wb_valid) begin
      if (wq.size() == 0) chk("wb_unexpected", wb_valid, 0);
      else begin
        wb_t e;
        e = wq.pop_front();
        chk("wb_data", wb_data, e.d);
        chk("err_timeout", err_timeout, e.err);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("misalign", misalign, e.mis);
`endif
      end
    end else if (err_timeout) chk("err_without_wb", err_timeout, 0);
  end

  // Reference model: computes the expected port values and completion cycle from the access rules.
  task automatic do_op(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input int rd, input int dv, input logic [31:0] rdata, input bit idle_after);
    int size, a, exp_cyc, k;
    bit st, sgn, trap, seen;
    logic [31:0] sh, ewb;
    logic [3:0] mask;
    req_t r;
    wb_t w;
    st = (op >= 5'b10010);
    sgn = (op == 5'b01110) || (op == 5'b10000);
    size = (op == 5'b01101 || op == 5'b10010) ? 4 :
           (op == 5'b01110 || op == 5'b01111 || op == 5'b10011) ? 2 : 1;
    a = int'(addr[1:0]);
    trap = 0;
`ifdef MEM_MISALIGN_TRAP_EN
    trap = (a % size) != 0;
`endif
    a = a - (a % size);
    mask = (size == 4) ? 4'hF : (size == 2) ? 4'h3 : 4'h1;
    sh = rdata >> (8 * a);
    if (size == 4) ewb = sh;
    else if (size == 2) ewb = sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
    else ewb = sgn ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
    w.err = 0; w.mis = 0;
    if (trap) begin
      exp_cyc = 1; w.d = 0; w.mis = 1;
    end else begin
      r.addr = addr & 32'hFFFF_FFFC;
      r.be = 4'(mask << a);
      r.wd = (size == 4) ? wd : (size == 2) ? {2{wd[15:0]}} : {4{wd[7:0]}};
      r.we = st;
      rq.push_back(r);
      if (st) begin exp_cyc = rd + 2; w.d = 0; end
      else if (dv <= MAX_WAIT) begin exp_cyc = rd + dv + 2; w.d = ewb; end
      else begin exp_cyc = rd + MAX_WAIT + 2; w.d = 0; w.err = 1; end
    end
    wq.push_back(w);

    @(posedge clk); #1;
    ex_valid = 1; ex_opcode = op; ex_addr = addr; ex_wdata = wd;
    mem_ready = 0; mem_rvalid = 0;
    @(negedge clk);
    chk("stall_accept", stall, 1);
    seen = 0;
    for (k = 1; k <= rd + MAX_WAIT + 6 && !seen; k++) begin
      @(posedge clk); #1;
      // Changing operands while busy must not start another access.
      ex_valid = 1; ex_opcode = 5'($urandom); ex_addr = $urandom; ex_wdata = $urandom;
      if (trap) begin
        mem_ready = 0; mem_rvalid = 0;
      end else if (k <= rd + 1) begin
        mem_ready = (k == rd + 1); mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      end else begin
        mem_ready = 0;
        mem_rvalid = !st && (k == rd + 1 + dv);
        mem_rdata = mem_rvalid ? rdata : $urandom;
      end
      @(negedge clk);
      if (wb_valid) begin
        chk("latency", k, exp_cyc);
        chk("stall_done", stall, 0);
        seen = 1;
      end
    end
    if (!seen) chk("wb_seen", wb_valid, 1);
    if (idle_after) begin
      @(posedge clk); #1;
      ex_valid = 0; mem_ready = 0; mem_rvalid = 0;
      @(negedge clk);
      chk("stall_idle", stall, 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_wb_valid"}, wb_valid, 0);
    chk({tag, "_wb_data"}, wb_data, 0);
    chk({tag, "_err"}, err_timeout, 0);
    chk({tag, "_req"}, mem_req, 0);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_be"}, mem_be, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst_n = 1;

    // Non-memory opcode must not stall or start anything.
    ex_valid = 1; ex_opcode = 5'b00000;
    @(negedge clk); chk("nonmem_stall", stall, 0);
    @(posedge clk); #1 ex_opcode = 5'b11111;
    @(negedge clk); chk("nonmem_stall2", stall, 0); chk("nonmem_req", mem_req, 0);
    @(posedge clk); #1 ex_valid = 0;

    do_op(5'b01101, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF, 1);            // LW
    do_op(5'b10000, 32'h103, 32'h0, 0, 1, 32'h80FF_0000, 1);           // LB
    do_op(5'b10001, 32'h103, 32'h0, 0, 1, 32'h80FF_0000, 0);           // LBU back-to-back
    do_op(5'b10011, 32'h202, 32'h0000ABCD, 4, 1, 32'h0, 1);            // SH, ready late
    do_op(5'b01101, 32'h010, 32'h0, 0, MAX_WAIT + 1, 32'h1234, 1);     // timeout
    do_op(5'b01110, 32'h022, 32'h0, 1, MAX_WAIT, 32'h8001_7FFF, 1);    // rvalid at expiry
    do_op(5'b01101, 32'h102, 32'h0, 0, 1, 32'hCAFEF00D, 1);            // misaligned LW
    do_op(5'b01111, 32'h301, 32'h0, 0, 2, 32'hF00D_8123, 1);           // misaligned LHU

    // Reset during WAIT aborts the load; a late rvalid must be ignored.
    begin
      req_t r;
      r.addr = 32'h40; r.be = 4'hF; r.wd = 0; r.we = 0;
      rq.push_back(r);
      @(posedge clk); #1 ex_valid = 1; ex_opcode = 5'b01101; ex_addr = 32'h40;
      @(posedge clk); #1 ex_valid = 0; mem_ready = 1;
      @(posedge clk); #1 mem_ready = 0; rst_n = 0;
      @(posedge clk); #1;
      check_all_zero("midrst");
      rst_n = 1; mem_rvalid = 1; mem_rdata = 32'h5555_AAAA;
      @(posedge clk); #1 mem_rvalid = 0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk); chk("late_rvalid_wb", wb_valid, 0); chk("late_rvalid_stall", stall, 0);
      end
    end
    do_op(5'b10100, 32'h001, 32'h0000005A, 0, 1, 32'h0, 1);            // SB

    for (int i = 0; i < 150; i++) begin
      int rd, dv;
      rd = $urandom_range(0, 3);
      dv = ($urandom_range(0, 7) == 0) ? $urandom_range(MAX_WAIT - 1, MAX_WAIT + 1)
                                       : $urandom_range(1, 3);
      do_op(OPS[$urandom_range(0, 7)], $urandom, $urandom, rd, dv, $urandom,
            1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("req_queue_empty", rq.size(), 0);
    chk("wb_queue_empty", wq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
